// File: rtl/polara_loopback_noc_arb_if.sv
// Link bundle between the three loopback generators, the arbiter and the chipset serializer.
interface polara_loopback_noc_arb_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              go;
  logic [DATA_W-1:0] in_data_noc1;
  logic [DATA_W-1:0] in_data_noc2;
  logic [DATA_W-1:0] in_data_noc3;
  logic              in_val_noc1;
  logic              in_val_noc2;
  logic              in_val_noc3;
  logic              in_rdy_noc1;
  logic              in_rdy_noc2;
  logic              in_rdy_noc3;
  logic [DATA_W-1:0] out_data;
  logic              out_val;
  logic              out_rdy;
  logic [1:0]        out_chan;
  logic              busy;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              wdog_err;

  modport master (
    output go, in_data_noc1, in_data_noc2, in_data_noc3,
    output in_val_noc1, in_val_noc2, in_val_noc3, out_rdy,
    input  in_rdy_noc1, in_rdy_noc2, in_rdy_noc3,
    input  out_data, out_val, out_chan, busy, pkt_cnt, wdog_err
  );

  modport slave (
    input  go, in_data_noc1, in_data_noc2, in_data_noc3,
    input  in_val_noc1, in_val_noc2, in_val_noc3, out_rdy,
    output in_rdy_noc1, in_rdy_noc2, in_rdy_noc3,
    output out_data, out_val, out_chan, busy, pkt_cnt, wdog_err
  );
endinterface

// File: rtl/polara_loopback_noc_arb.sv
// Packet-atomic round-robin arbiter sharing one outbound chipset link among NoC1..NoC3.
// Optional BODY-stall watchdog is compiled in with POLARA_LOOPBACK_ARB_WDOG_EN.
module polara_loopback_noc_arb #(
  parameter int DATA_W      = 64,
  parameter int LEN_LSB     = 22,
  parameter int LEN_W       = 8,
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                      chipset_clk,
  input  logic                      chip_rst,
  polara_loopback_noc_arb_if.slave  link
);
  typedef enum logic {ARB, BODY} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        rr_ptr_reg, rr_ptr_next;
  logic [1:0]        owner_reg, owner_next;
  logic [LEN_W-1:0]  remaining_reg, remaining_next;
  logic [CNT_W-1:0]  pkt_cnt_reg, pkt_cnt_next;

  logic [3:0]        val_vec;
  logic [DATA_W-1:0] data_arr [4];
  logic [1:0]        grant, cand1, cand2;
  logic [3:1]        rdy_vec;
  logic              out_val, hs, abandon;
  logic [LEN_W-1:0]  hdr_len;

  if (WDOG_CYCLES < 1) begin : g_wdog_chk
    $error("WDOG_CYCLES must be at least 1");
  end

  function automatic logic [1:0] nxt(input logic [1:0] c);
    return (c == 2'd3) ? 2'd1 : c + 2'd1;
  endfunction

  // Index 0 means "no channel", so its valid and data are held at zero.
  assign val_vec     = {link.in_val_noc3, link.in_val_noc2, link.in_val_noc1, 1'b0};
  assign data_arr[0] = '0;
  assign data_arr[1] = link.in_data_noc1;
  assign data_arr[2] = link.in_data_noc2;
  assign data_arr[3] = link.in_data_noc3;

  always_comb begin
    cand1 = nxt(rr_ptr_reg);
    cand2 = nxt(cand1);
    grant = 2'd0;
    if (state_reg == BODY) begin
      grant = owner_reg;
    end else if (link.go) begin
      if (val_vec[rr_ptr_reg])  grant = rr_ptr_reg;
      else if (val_vec[cand1])  grant = cand1;
      else if (val_vec[cand2])  grant = cand2;
    end
  end

  assign out_val       = val_vec[grant];
  assign hs            = out_val && link.out_rdy;
  assign hdr_len       = data_arr[grant][LEN_LSB +: LEN_W];
  assign link.out_val  = out_val;
  assign link.out_data = out_val ? data_arr[grant] : '0;
  assign link.out_chan = grant;
  assign link.busy     = (state_reg == BODY);
  assign link.pkt_cnt  = pkt_cnt_reg;

  for (genvar gi = 1; gi <= 3; gi++) begin : g_rdy
    assign rdy_vec[gi] = (grant == 2'(gi)) && link.out_rdy;
  end
  assign link.in_rdy_noc1 = rdy_vec[1];
  assign link.in_rdy_noc2 = rdy_vec[2];
  assign link.in_rdy_noc3 = rdy_vec[3];

`ifdef POLARA_LOOPBACK_ARB_WDOG_EN
  localparam int STALL_W = $clog2(WDOG_CYCLES + 1);
  logic [STALL_W-1:0] stall_reg;
  logic               wdog_err_reg;

  // Abandon on the cycle that would make the stall run reach WDOG_CYCLES.
  assign abandon       = (state_reg == BODY) && !hs && (stall_reg == STALL_W'(WDOG_CYCLES - 1));
  assign link.wdog_err = wdog_err_reg;

  always_ff @(posedge chipset_clk) begin
    if (chip_rst) begin
      stall_reg    <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      if (state_reg != BODY || hs || abandon) stall_reg <= '0;
      else                                    stall_reg <= stall_reg + 1'b1;
      if (abandon) wdog_err_reg <= 1'b1;
    end
  end
`else
  assign abandon       = 1'b0;
  assign link.wdog_err = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    owner_next     = owner_reg;
    remaining_next = remaining_reg;
    pkt_cnt_next   = pkt_cnt_reg;
    case (state_reg)
      ARB: begin
        if (hs) begin
          if (hdr_len == '0) begin
            pkt_cnt_next = pkt_cnt_reg + 1'b1;
            rr_ptr_next  = nxt(grant);
          end else begin
            remaining_next = hdr_len;
            owner_next     = grant;
            state_next     = BODY;
          end
        end
      end
      BODY: begin
        if (hs) begin
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == LEN_W'(1)) begin
            pkt_cnt_next = pkt_cnt_reg + 1'b1;
            rr_ptr_next  = nxt(owner_reg);
            state_next   = ARB;
          end
        end else if (abandon) begin
          remaining_next = '0;
          rr_ptr_next    = nxt(owner_reg);
          state_next     = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge chipset_clk) begin
    if (chip_rst) begin
      state_reg     <= ARB;
      rr_ptr_reg    <= 2'd1;
      owner_reg     <= 2'd1;
      remaining_reg <= '0;
      pkt_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      owner_reg     <= owner_next;
      remaining_reg <= remaining_next;
      pkt_cnt_reg   <= pkt_cnt_next;
    end
  end
endmodule

// File: tb/tb_polara_loopback_noc_arb.sv
// Directed bench for polara_loopback_noc_arb; watchdog steps follow POLARA_LOOPBACK_ARB_WDOG_EN.
module tb_polara_loopback_noc_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  polara_loopback_noc_arb_if #(.DATA_W(64), .CNT_W(16)) link ();

  polara_loopback_noc_arb #(
    .DATA_W(64), .LEN_LSB(22), .LEN_W(8), .CNT_W(16), .WDOG_CYCLES(8)
  ) u_dut (
    .chipset_clk(clk),
    .chip_rst   (rst),
    .link       (link)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [15:0] tag, input logic [7:0] len);
    logic [63:0] r;
    r = '0;
    r[63:48] = tag;
    r[29:22] = len;
    r[7:0]   = 8'hA5;
    return r;
  endfunction

  function automatic logic [63:0] pl(input logic [15:0] tag, input logic [7:0] idx);
    logic [63:0] r;
    r = 64'hDA7A_0000_0000_0000;
    r[47:32] = tag;
    r[7:0]   = idx;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    link.in_val_noc1 = 1'b0;
    link.in_val_noc2 = 1'b0;
    link.in_val_noc3 = 1'b0;
  endtask

  initial begin
    link.go = 1'b0; link.out_rdy = 1'b0;
    link.in_data_noc1 = '0; link.in_data_noc2 = '0; link.in_data_noc3 = '0;
    clr();

    // Reset state
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_out_val", 64'(link.out_val), 64'd0);
    chk("rst_out_data", link.out_data, 64'd0);
    chk("rst_out_chan", 64'(link.out_chan), 64'd0);
    chk("rst_busy", 64'(link.busy), 64'd0);
    chk("rst_pkt_cnt", 64'(link.pkt_cnt), 64'd0);
    chk("rst_in_rdy", 64'({link.in_rdy_noc1, link.in_rdy_noc2, link.in_rdy_noc3}), 64'd0);
    chk("rst_wdog", 64'(link.wdog_err), 64'd0);

    // NoC1 alone, len=2
    link.go = 1'b1; link.out_rdy = 1'b1;
    link.in_val_noc1 = 1'b1; link.in_data_noc1 = mk(16'h1, 8'd2); #1;
    chk("t1_hdr_chan", 64'(link.out_chan), 64'd1);
    chk("t1_hdr_data", link.out_data, mk(16'h1, 8'd2));
    chk("t1_hdr_rdy", 64'({link.in_rdy_noc1, link.in_rdy_noc2, link.in_rdy_noc3}), 64'b100);
    chk("t1_hdr_busy", 64'(link.busy), 64'd0);
    tick();
    link.in_data_noc1 = pl(16'h1, 8'd1); #1;
    chk("t1_p1_data", link.out_data, pl(16'h1, 8'd1));
    chk("t1_p1_chan", 64'(link.out_chan), 64'd1);
    chk("t1_p1_busy", 64'(link.busy), 64'd1);
    tick();
    link.in_data_noc1 = pl(16'h1, 8'd2); #1;
    chk("t1_p2_data", link.out_data, pl(16'h1, 8'd2));
    chk("t1_p2_busy", 64'(link.busy), 64'd1);
    tick();
    clr(); #1;
    chk("t1_cnt", 64'(link.pkt_cnt), 64'd1);
    chk("t1_idle_busy", 64'(link.busy), 64'd0);
    chk("t1_idle_val", 64'(link.out_val), 64'd0);
    chk("t1_idle_chan", 64'(link.out_chan), 64'd0);

    // Reset to restore rr_ptr=NoC1, then round robin of len=0 packets
    rst = 1'b1; tick(); rst = 1'b0; #1;
    chk("t2_rst_cnt", 64'(link.pkt_cnt), 64'd0);
    link.in_data_noc1 = mk(16'h1, 8'd0);
    link.in_data_noc2 = mk(16'h2, 8'd0);
    link.in_data_noc3 = mk(16'h3, 8'd0);
    link.in_val_noc1 = 1'b1; link.in_val_noc2 = 1'b1; link.in_val_noc3 = 1'b1; #1;
    chk("t2_g0", 64'(link.out_chan), 64'd1);
    tick();
    chk("t2_g1", 64'(link.out_chan), 64'd2);
    chk("t2_g1_data", link.out_data, mk(16'h2, 8'd0));
    tick();
    chk("t2_g2", 64'(link.out_chan), 64'd3);
    chk("t2_g2_rdy", 64'({link.in_rdy_noc1, link.in_rdy_noc2, link.in_rdy_noc3}), 64'b001);
    tick();
    chk("t2_g3", 64'(link.out_chan), 64'd1);
    tick();
    chk("t2_cnt", 64'(link.pkt_cnt), 64'd4);
    clr();

    // NoC1 len=3 with NoC2 waiting, out_rdy toggling
    rst = 1'b1; tick(); rst = 1'b0;
    link.in_data_noc1 = mk(16'h1, 8'd3); link.in_data_noc2 = mk(16'h2, 8'd0);
    link.in_val_noc1 = 1'b1; link.in_val_noc2 = 1'b1; link.out_rdy = 1'b1; #1;
    chk("t3_hdr_chan", 64'(link.out_chan), 64'd1);
    chk("t3_hdr_rdy2", 64'(link.in_rdy_noc2), 64'd0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      link.in_data_noc1 = pl(16'h1, 8'(i));
      link.out_rdy = 1'b0; #1;
      chk("t3_stall_chan", 64'(link.out_chan), 64'd1);
      chk("t3_stall_rdy", 64'({link.in_rdy_noc1, link.in_rdy_noc2, link.in_rdy_noc3}), 64'd0);
      tick();
      link.out_rdy = 1'b1; #1;
      chk("t3_p_data", link.out_data, pl(16'h1, 8'(i)));
      chk("t3_p_rdy2", 64'(link.in_rdy_noc2), 64'd0);
      tick();
    end
    link.in_val_noc1 = 1'b0; #1;
    chk("t3_n2_chan", 64'(link.out_chan), 64'd2);
    chk("t3_n2_data", link.out_data, mk(16'h2, 8'd0));
    chk("t3_n2_rdy", 64'(link.in_rdy_noc2), 64'd1);
    tick();
    chk("t3_cnt", 64'(link.pkt_cnt), 64'd2);
    clr();

    // NoC3 len=4, go dropped mid-packet
    link.in_data_noc3 = mk(16'h3, 8'd4); link.in_val_noc3 = 1'b1; #1;
    chk("t4_hdr_chan", 64'(link.out_chan), 64'd3);
    tick();
    link.go = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      link.in_data_noc3 = pl(16'h3, 8'(i)); #1;
      chk("t4_p_data", link.out_data, pl(16'h3, 8'(i)));
      chk("t4_p_chan", 64'(link.out_chan), 64'd3);
      tick();
    end
    clr();
    link.in_data_noc1 = mk(16'h1, 8'd0); link.in_val_noc1 = 1'b1;
    link.in_data_noc2 = mk(16'h2, 8'd0); link.in_val_noc2 = 1'b1; #1;
    chk("t4_cnt", 64'(link.pkt_cnt), 64'd3);
    chk("t4_nogo_val", 64'(link.out_val), 64'd0);
    chk("t4_nogo_chan", 64'(link.out_chan), 64'd0);
    chk("t4_nogo_data", link.out_data, 64'd0);
    tick();
    chk("t4_nogo_cnt", 64'(link.pkt_cnt), 64'd3);
    link.go = 1'b1; #1;
    chk("t4_go_chan", 64'(link.out_chan), 64'd1);
    tick();
    chk("t4_go_cnt", 64'(link.pkt_cnt), 64'd4);
    clr();

    // Reset with remaining=2 (rr_ptr now NoC2)
    link.in_data_noc2 = mk(16'h2, 8'd2); link.in_val_noc2 = 1'b1; #1;
    chk("t5_hdr_chan", 64'(link.out_chan), 64'd2);
    tick();
    chk("t5_busy_pre", 64'(link.busy), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    clr(); #1;
    chk("t5_busy", 64'(link.busy), 64'd0);
    chk("t5_cnt", 64'(link.pkt_cnt), 64'd0);
    chk("t5_val", 64'(link.out_val), 64'd0);
    link.in_data_noc1 = mk(16'h1, 8'd0); link.in_data_noc3 = mk(16'h3, 8'd0);
    link.in_data_noc2 = mk(16'h2, 8'd0);
    link.in_val_noc1 = 1'b1; link.in_val_noc2 = 1'b1; link.in_val_noc3 = 1'b1; #1;
    chk("t5_rr", 64'(link.out_chan), 64'd1);
    tick();
    clr();

    // NoC2 len=2 then owner stalls for 8 cycles
    link.in_data_noc2 = mk(16'h2, 8'd2); link.in_val_noc2 = 1'b1; #1;
    chk("t6_hdr_chan", 64'(link.out_chan), 64'd2);
    tick();
    link.in_val_noc2 = 1'b0;
    repeat (7) tick();
    chk("t6_stall_busy", 64'(link.busy), 64'd1);
    chk("t6_stall_val", 64'(link.out_val), 64'd0);
    chk("t6_stall_chan", 64'(link.out_chan), 64'd2);
    tick();
`ifdef POLARA_LOOPBACK_ARB_WDOG_EN
    chk("t6_wd_busy", 64'(link.busy), 64'd0);
    chk("t6_wd_err", 64'(link.wdog_err), 64'd1);
    chk("t6_wd_cnt", 64'(link.pkt_cnt), 64'd1);
`else
    chk("t6_nowd_busy", 64'(link.busy), 64'd1);
    chk("t6_nowd_err", 64'(link.wdog_err), 64'd0);
    link.in_val_noc2 = 1'b1; link.in_data_noc2 = pl(16'h2, 8'd1); #1;
    chk("t6_nowd_p1", link.out_data, pl(16'h2, 8'd1));
    tick();
    link.in_data_noc2 = pl(16'h2, 8'd2); tick();
    link.in_val_noc2 = 1'b0; #1;
    chk("t6_nowd_cnt", 64'(link.pkt_cnt), 64'd2);
    chk("t6_nowd_idle", 64'(link.busy), 64'd0);
`endif
    link.in_data_noc1 = mk(16'h1, 8'd0); link.in_data_noc3 = mk(16'h3, 8'd0);
    link.in_val_noc1 = 1'b1; link.in_val_noc3 = 1'b1; #1;
    chk("t6_next_chan", 64'(link.out_chan), 64'd3);
    tick();
    clr();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/polara_loopback_noc_arb.md
Name: polara_loopback_noc_arb

Overview:
- Packet-atomic round-robin arbiter that shares one 64-bit outbound chipset link between the three loopback packet generator streams (NoC1, NoC2, NoC3).
- Sits between the loopback packet generators and the chipset interface serializer.
- Gated by the same `go` control the generators use.
- Never interleaves flits of different packets, and reports a packet count and busy status for on-board debug.

Parameters:
- DATA_W, 64: flit width.
- LEN_LSB, 22: LSB of the payload-length field in the header flit.
- LEN_W, 8: width of the payload-length field (payload flits following the header).
- CNT_W, 16: width of the completed-packet counter.
- WDOG_CYCLES, 1024: stall limit for the optional watchdog.

Ports:
- chipset_clk, in, 1: clock.
- chip_rst, in, 1: synchronous active-high reset.
- go, in, 1: enables new grants.
- in_data_noc1/2/3, in, DATA_W each: generator flit data.
- in_val_noc1/2/3, in, 1 each: generator flit valid.
- in_rdy_noc1/2/3, out, 1 each: ready back to each generator.
- out_data, out, DATA_W: shared link data.
- out_val, out, 1: shared link valid.
- out_rdy, in, 1: shared link ready.
- out_chan, out, 2: owning channel (1..3); 0 when no channel is granted.
- busy, out, 1: high while a packet is mid-transfer (BODY state).
- pkt_cnt, out, CNT_W: completed packets since reset.
- wdog_err, out, 1: sticky watchdog error; tied 0 when the optional feature is compiled out.

Behaviour:
- Interface: one clock (chipset_clk); chip_rst is synchronous and active-high.
- Reset (chip_rst=1 at a clock edge) sets:
  - state=ARB, rr_ptr=NoC1, remaining=0, pkt_cnt=0, wdog_err=0.
  - Combinational outputs then evaluate to out_val=0, out_data=0, in_rdy_*=0, out_chan=0, busy=0.
- Datapath:
  - Zero-latency, unbuffered mux.
  - out_data/out_val follow the granted channel's data/valid; in_rdy of the granted channel = out_rdy; all other in_rdy=0.
  - Handshake occurs when out_val && out_rdy.
  - out_data=0 whenever out_val=0.
- State ARB:
  - If go=1 and any in_val is high, grant goes combinationally to the first valid channel at or after rr_ptr, in order NoC1→NoC2→NoC3 with wrap.
  - The header transfers in the same cycle if out_rdy=1.
  - If go=0: no grant, out_chan=0.
  - On header handshake, len = header[LEN_LSB+LEN_W-1:LEN_LSB]:
    - len==0: packet complete; pkt_cnt++; rr_ptr = grant+1 (wrap 3→1); stay in ARB.
    - len>0: remaining=len; grant is latched; go to BODY.
  - If out_rdy=0, no state change and no latch; arbitration is re-evaluated the next cycle, so the grant may change before the header is accepted.
- State BODY:
  - Grant is fixed to the latched channel; go and other channels' valids are ignored.
  - Each handshake decrements remaining.
  - Handshake with remaining==1: pkt_cnt++, rr_ptr = latched+1, go to ARB.
  - in_val low on the owning channel: out_val=0; wait, no abort (unless watchdog is enabled).
- go deasserted mid-packet: the current packet still completes; no new grant follows until go=1.
- pkt_cnt wraps modulo 2^CNT_W.
- busy=1 exactly while in BODY.
- Reset mid-packet: returns to ARB immediately. The upstream generators are reset by the same event, so partial packets are not resumed.

Optional Feature:
- POLARA_LOOPBACK_ARB_WDOG_EN defined:
  - In BODY, a stall counter counts consecutive cycles without a handshake and clears on every handshake.
  - On reaching WDOG_CYCLES, the packet is abandoned: state=ARB, rr_ptr = latched+1, pkt_cnt unchanged, wdog_err set.
  - wdog_err is sticky until chip_rst.
- Not defined: no stall counter; BODY waits indefinitely; wdog_err is tied 0.

Test Plan:
- Reset, then go=1 with only NoC1 valid, header len=2, out_rdy=1 → 3 flits on out_data, out_chan=1 for 3 cycles, busy high for 2 cycles, pkt_cnt=1.
- All three channels valid with len=0 headers, out_rdy=1, go=1 → grant order 1,2,3,1 on consecutive cycles; pkt_cnt=4 after 4 cycles.
- NoC1 sends header len=3; NoC2 valid throughout; out_rdy toggles 1,0,1,0 → no NoC2 flit appears until NoC1's 3rd payload flit is accepted; in_rdy_noc2=0 during that time.
- go=0 mid NoC3 packet (len=4) → all 4 payload flits still complete, then out_val=0 and out_chan=0 while go=0; go=1 → next grant goes to NoC1.
- chip_rst pulsed with remaining=2 → next cycle state=ARB, pkt_cnt=0, out_val=0, rr_ptr=NoC1.
- With the watchdog macro defined and WDOG_CYCLES=8: NoC2 header len=2, then in_val_noc2=0 for 8 cycles → wdog_err=1, pkt_cnt unchanged, next grant available to NoC3.
